// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_pkg
// Description : Shared XGMII constants, link-fault encoding and the
//               sequence-column classifier used by the RS link-fault stage.
// Revision    : 1.0 - initial release
// ============================================================================
package xgmii_pkg;

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } link_fault_t;

    localparam logic [63:0] XGMII_IDLE_D  = 64'h0707070707070707;
    localparam logic [7:0]  XGMII_IDLE_C  = 8'hFF;
    localparam logic [7:0]  XGMII_SEQ     = 8'h9C;
    localparam logic [7:0]  XGMII_ERR     = 8'hFE;
    localparam logic [63:0] XGMII_RF_WORD = 64'h0200009C0200009C;
    localparam logic [7:0]  XGMII_RF_C    = 8'h11;

    // Classify one 4-lane column: LF_LOCAL / LF_REMOTE for a fault sequence
    // ordered set, LF_OK for anything else.
    function automatic link_fault_t seq_type(input logic [31:0] d, input logic [3:0] c);
        link_fault_t t;
        t = LF_OK;
        if (c == 4'b0001 && d[7:0] == XGMII_SEQ && d[23:8] == 16'h0000) begin
            if (d[31:24] == 8'h01) begin
                t = LF_LOCAL;
            end else if (d[31:24] == 8'h02) begin
                t = LF_REMOTE;
            end
        end
        return t;
    endfunction

endpackage : xgmii_pkg
`default_nettype wire

// File: rtl/xgmii_fault_col_step.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_fault_col_step
// Description : Combinational link-fault state update for a single XGMII
//               column. Two instances are chained to cover a 64-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii_fault_col_step
    import xgmii_pkg::*;
#(
    parameter int COL_WINDOW      = 128,
    parameter int FAULT_SEQ_COUNT = 4,
    parameter int COL_W           = 8,
    parameter int SEQ_W           = 3
) (
    input  logic [31:0]      col_d,
    input  logic [3:0]       col_c,
    input  logic [SEQ_W-1:0] seq_cnt_in,
    input  logic [COL_W-1:0] col_cnt_in,
    input  logic [1:0]       last_type_in,
    input  logic [1:0]       link_fault_in,
    output logic [SEQ_W-1:0] seq_cnt_out,
    output logic [COL_W-1:0] col_cnt_out,
    output logic [1:0]       last_type_out,
    output logic [1:0]       link_fault_out
);

    localparam logic [COL_W-1:0] c_col_window = COL_W'(COL_WINDOW);
    localparam logic [SEQ_W-1:0] c_seq_count  = SEQ_W'(FAULT_SEQ_COUNT);

    link_fault_t w_type;

    // Apply the sequence / non-sequence rules to the incoming state.
    always_comb begin
        w_type         = seq_type(col_d, col_c);
        seq_cnt_out    = seq_cnt_in;
        col_cnt_out    = col_cnt_in;
        last_type_out  = last_type_in;
        link_fault_out = link_fault_in;
        if (w_type != LF_OK) begin
            col_cnt_out = '0;
            if (w_type == last_type_in && col_cnt_in < c_col_window) begin
                // Same type inside the window: keep counting, hold at the threshold.
                if (seq_cnt_in < c_seq_count) begin
                    seq_cnt_out = seq_cnt_in + SEQ_W'(1);
                end
            end else begin
                // New type or stale run: this sequence starts a fresh run.
                last_type_out = w_type;
                seq_cnt_out   = SEQ_W'(1);
            end
            if (seq_cnt_out >= c_seq_count) begin
                link_fault_out = w_type;
            end
        end else begin
            if (col_cnt_in < c_col_window) begin
                col_cnt_out = col_cnt_in + COL_W'(1);
            end
            if (col_cnt_out >= c_col_window) begin
                seq_cnt_out    = '0;
                link_fault_out = LF_OK;
            end
        end
    end

endmodule : xgmii_fault_col_step
`default_nettype wire

// File: rtl/xgmii_link_fault_rs.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_link_fault_rs
// Description : 10GBASE-R Reconciliation Sublayer link-fault stage. Detects
//               local/remote fault sequences on RX and overrides TX with
//               remote-fault or idle columns while a fault is active.
//               Optional statistics counters: XGMII_LINK_FAULT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii_link_fault_rs
    import xgmii_pkg::*;
#(
    parameter int COL_WINDOW      = 128,
    parameter int FAULT_SEQ_COUNT = 4,
    parameter int STAT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           rx_xgmii_d,
    input  logic [7:0]            rx_xgmii_c,
    input  logic [63:0]           tx_xgmii_d_in,
    input  logic [7:0]            tx_xgmii_c_in,
    output logic [63:0]           tx_xgmii_d_out,
    output logic [7:0]            tx_xgmii_c_out,
    output logic [1:0]            link_fault,
    output logic                  link_up,
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] stat_err_cnt,
    output logic [STAT_WIDTH-1:0] stat_fault_cnt
);

    localparam int COL_W = $clog2(COL_WINDOW + 1);
    localparam int SEQ_W = $clog2(FAULT_SEQ_COUNT + 1);

    logic [SEQ_W-1:0] r_seq_cnt;
    logic [COL_W-1:0] r_col_cnt;
    logic [1:0]       r_last_type;
    link_fault_t      r_link_fault;
    logic [63:0]      r_tx_d;
    logic [7:0]       r_tx_c;

    logic [SEQ_W-1:0] w_seq_cnt0, w_seq_cnt1;
    logic [COL_W-1:0] w_col_cnt0, w_col_cnt1;
    logic [1:0]       w_last_type0, w_last_type1;
    logic [1:0]       w_link_fault0, w_link_fault1;

    xgmii_fault_col_step #(
        .COL_WINDOW(COL_WINDOW), .FAULT_SEQ_COUNT(FAULT_SEQ_COUNT), .COL_W(COL_W), .SEQ_W(SEQ_W)
    ) u_col0 (
        .col_d(rx_xgmii_d[31:0]), .col_c(rx_xgmii_c[3:0]),
        .seq_cnt_in(r_seq_cnt), .col_cnt_in(r_col_cnt),
        .last_type_in(r_last_type), .link_fault_in(r_link_fault),
        .seq_cnt_out(w_seq_cnt0), .col_cnt_out(w_col_cnt0),
        .last_type_out(w_last_type0), .link_fault_out(w_link_fault0)
    );

    xgmii_fault_col_step #(
        .COL_WINDOW(COL_WINDOW), .FAULT_SEQ_COUNT(FAULT_SEQ_COUNT), .COL_W(COL_W), .SEQ_W(SEQ_W)
    ) u_col1 (
        .col_d(rx_xgmii_d[63:32]), .col_c(rx_xgmii_c[7:4]),
        .seq_cnt_in(w_seq_cnt0), .col_cnt_in(w_col_cnt0),
        .last_type_in(w_last_type0), .link_fault_in(w_link_fault0),
        .seq_cnt_out(w_seq_cnt1), .col_cnt_out(w_col_cnt1),
        .last_type_out(w_last_type1), .link_fault_out(w_link_fault1)
    );

    // Commit the column-1 result as the fault state for the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_cnt    <= '0;
            r_col_cnt    <= '0;
            r_last_type  <= LF_OK;
            r_link_fault <= LF_OK;
        end else begin
            r_seq_cnt    <= w_seq_cnt1;
            r_col_cnt    <= w_col_cnt1;
            r_last_type  <= w_last_type1;
            r_link_fault <= link_fault_t'(w_link_fault1);
        end
    end

    // TX register: pass through when OK, send RF on local fault, idle on remote.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_d <= XGMII_IDLE_D;
            r_tx_c <= XGMII_IDLE_C;
        end else begin
            case (r_link_fault)
                LF_OK: begin
                    r_tx_d <= tx_xgmii_d_in;
                    r_tx_c <= tx_xgmii_c_in;
                end
                LF_LOCAL: begin
                    r_tx_d <= XGMII_RF_WORD;
                    r_tx_c <= XGMII_RF_C;
                end
                default: begin
                    r_tx_d <= XGMII_IDLE_D;
                    r_tx_c <= XGMII_IDLE_C;
                end
            endcase
        end
    end

    assign tx_xgmii_d_out = r_tx_d;
    assign tx_xgmii_c_out = r_tx_c;
    assign link_fault     = r_link_fault;
    assign link_up        = (r_link_fault == LF_OK);

`ifdef XGMII_LINK_FAULT_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_err_cnt;
    logic [STAT_WIDTH-1:0] r_stat_fault_cnt;
    logic                  w_err_word;
    logic                  w_fault_rise;

    // Flag a word carrying /E/ in any control lane.
    always_comb begin
        w_err_word = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rx_xgmii_c[i] && rx_xgmii_d[8*i +: 8] == XGMII_ERR) begin
                w_err_word = 1'b1;
            end
        end
    end

    assign w_fault_rise = (r_link_fault == LF_OK) && (w_link_fault1 != LF_OK);

    // Saturating statistics; a clear overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            r_stat_err_cnt   <= '0;
            r_stat_fault_cnt <= '0;
        end else begin
            if (w_err_word && r_stat_err_cnt != '1) begin
                r_stat_err_cnt <= r_stat_err_cnt + STAT_WIDTH'(1);
            end
            if (w_fault_rise && r_stat_fault_cnt != '1) begin
                r_stat_fault_cnt <= r_stat_fault_cnt + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_err_cnt   = r_stat_err_cnt;
    assign stat_fault_cnt = r_stat_fault_cnt;
`else
    logic w_unused;
    assign w_unused       = stat_clear;
    assign stat_err_cnt   = '0;
    assign stat_fault_cnt = '0;
`endif

endmodule : xgmii_link_fault_rs
`default_nettype wire

// File: doc/xgmii_link_fault_rs.md
Name: xgmii_link_fault_rs

Overview:
- 10GBASE-R Reconciliation Sublayer link-fault stage. Sits between the network block and the XGMII interleave/deinterleave pair on the 156.25 MHz XGMII clock.
- RX path: monitors the deinterleaved 64-bit RX XGMII stream for local/remote fault sequence ordered sets and declares link fault state per the clause 46 algorithm.
- TX path: passes network TX XGMII to the interleaver with one register stage. Overrides it with remote-fault sequences or idles while a fault is active.

Parameters:
- COL_WINDOW, 128, non-sequence columns needed to clear a fault; also the maximum column gap between counted sequences.
- FAULT_SEQ_COUNT, 4, same-type sequences needed to declare a fault.
- STAT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk, input, 1, XGMII clock (156.25 MHz).
- rst, input, 1, reset; synchronous, active-high.
- rx_xgmii_d, input, 64, RX data; lane0 in [7:0] (column 0 = lanes 0-3, column 1 = lanes 4-7).
- rx_xgmii_c, input, 8, RX control, one bit per lane.
- tx_xgmii_d_in, input, 64, TX data from network.
- tx_xgmii_c_in, input, 8, TX control from network.
- tx_xgmii_d_out, output, 64, TX data to interleaver.
- tx_xgmii_c_out, output, 8, TX control to interleaver.
- link_fault, output, 2, 00 OK, 01 local fault, 10 remote fault.
- link_up, output, 1, high when link_fault==00.
- stat_clear, input, 1, clears statistics counters.
- stat_err_cnt, output, STAT_WIDTH, count of RX words containing /E/.
- stat_fault_cnt, output, STAT_WIDTH, count of OK->fault transitions.

Behaviour:
- Reset (sync, high) clears everything in one edge, including mid-sequence:
  - link_fault=00, link_up=1.
  - seq_cnt=0, col_cnt=0, last_type=00.
  - tx_xgmii_d_out=64'h0707070707070707, tx_xgmii_c_out=8'hFF.
  - counters=0.
- Sequence column definition:
  - lane0=8'h9C with c=1, lanes1-3 c=0, lanes1-2=8'h00.
  - lane3=8'h01 is local; lane3=8'h02 is remote; any other lane3 value is not a sequence.
- Each cycle processes column 0 then column 1 sequentially, chained combinationally; state registers at the end of the cycle.
- Per column:
  - Sequence of type T, T==last_type, col_cnt<COL_WINDOW: seq_cnt+1. If seq_cnt reaches FAULT_SEQ_COUNT, link_fault=T and seq_cnt holds. col_cnt=0.
  - Sequence of type T != last_type, or col_cnt>=COL_WINDOW: last_type=T, seq_cnt=1, col_cnt=0.
  - Non-sequence column: col_cnt+1, saturating at COL_WINDOW. On reaching COL_WINDOW: seq_cnt=0 and link_fault=00.
- Fault type switch (local<->remote) takes FAULT_SEQ_COUNT sequences of the new type; link_fault does not pass through 00 in between.
- link_fault and link_up update on the edge after the word that completes the condition.
- TX path, 1-cycle latency; selection uses the registered link_fault:
  - 00: register the inputs unchanged.
  - 01: output 64'h0200009C0200009C / 8'h11 (remote fault in both columns).
  - 10: output idle (64'h0707..07 / 8'hFF).
- Statistics counters saturate at all-ones.
  - stat_err_cnt: +1 per RX word with any lane c=1 and d=8'hFE.
  - stat_fault_cnt: +1 on a transition from 00 to non-00.
  - stat_clear asserted with an increment in the same cycle: clear wins, result 0.

Optional Feature:
- XGMII_LINK_FAULT_STATS_EN.
- Defined: both counters and stat_clear are functional.
- Undefined: counter logic is not generated; stat_err_cnt and stat_fault_cnt are tied to 0; stat_clear is ignored. Fault detection and TX behaviour are identical in both builds.

Decomposition:
- Shared package xgmii_pkg:
  - constants XGMII_IDLE_D/C, XGMII_SEQ=8'h9C, XGMII_ERR=8'hFE, XGMII_RF_WORD.
  - link_fault_t encoding (OK/LOCAL/REMOTE).
- One sub-module: xgmii_fault_col_step. It is a combinational per-column state update (seq_cnt, col_cnt, last_type, link_fault in -> out) and is instantiated twice, chained.

Test Plan:
- Idle stream, then 2 words each carrying 2 local-fault columns -> link_fault=01 the cycle after word 2. The next TX output is 64'h0200009C0200009C/8'h11 regardless of TX input.
- From 01: 64 idle words (128 columns) -> link_fault=00 after word 64, not after word 63. TX passthrough resumes one cycle later.
- 3 local sequences, then 1 remote, then 3 local -> link_fault stays 00. A 4th local sequence then sets 01.
- 1 local sequence per 65 words (130-column gap), repeated 10x -> link_fault stays 00.
- Remote fault declared -> TX output is idle while the input carries frames. stat_fault_cnt=1.
- 70000 words with /E/ -> stat_err_cnt=16'hFFFF. stat_clear with /E/ in the same cycle -> 0. rst asserted mid-sequence (seq_cnt=3) then 1 local sequence -> link_fault stays 00.
